// File: rtl/parity_lrc_gen.sv
// Streaming row-parity + LRC trailer generator with valid/ready handshakes.
// Optional input parity checker enabled by defining PARITY_CHECK_EN.
module parity_lrc_gen #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             odd_mode,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
`ifdef PARITY_CHECK_EN
    input  logic             s_parity,
    output logic             par_err,
    output logic [CNT_W-1:0] err_count,
`endif
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_parity,
    output logic             m_last,
    output logic             m_lrc,
    output logic [CNT_W-1:0] frames_done
);

    typedef enum logic {
        DATA,
        TRAILER
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             run_q;
    logic [WIDTH-1:0] lrc_acc;
    logic             frame_start;
    logic             mode_q;

    logic             slot_free;
    logic             in_fire;
    logic             trl_fire;
    logic             out_fire;
    logic             beat_mode;

    assign slot_free = !m_valid || m_ready;
    // run_q keeps s_ready low until the first clock after reset release
    assign s_ready   = run_q && (state == DATA) && slot_free;
    assign in_fire   = s_valid && s_ready;
    assign trl_fire  = (state == TRAILER) && slot_free;
    assign out_fire  = m_valid && m_ready;
    assign beat_mode = frame_start ? odd_mode : mode_q;

    always_comb begin
        state_nxt = state;
        unique case (state)
            DATA: begin
                if (in_fire && s_last) begin
                    state_nxt = TRAILER;
                end
            end
            TRAILER: begin
                if (slot_free) begin
                    state_nxt = DATA;
                end
            end
            default: state_nxt = DATA;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= DATA;
            run_q       <= 1'b0;
            lrc_acc     <= '0;
            frame_start <= 1'b1;
            mode_q      <= 1'b0;
            m_valid     <= 1'b0;
            m_data      <= '0;
            m_parity    <= 1'b0;
            m_last      <= 1'b0;
            m_lrc       <= 1'b0;
        end else begin
            state <= state_nxt;
            run_q <= 1'b1;
            if (in_fire) begin
                m_valid     <= 1'b1;
                m_data      <= s_data;
                m_parity    <= (^s_data) ^ beat_mode;
                m_last      <= 1'b0;
                m_lrc       <= 1'b0;
                lrc_acc     <= frame_start ? s_data : (lrc_acc ^ s_data);
                frame_start <= s_last;
                if (frame_start) begin
                    mode_q <= odd_mode;
                end
            end else if (trl_fire) begin
                // LRC itself is plain column XOR; only its row parity follows mode
                m_valid  <= 1'b1;
                m_data   <= lrc_acc;
                m_parity <= (^lrc_acc) ^ mode_q;
                m_last   <= 1'b1;
                m_lrc    <= 1'b1;
                lrc_acc  <= '0;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frames_done <= '0;
        end else if (out_fire && m_lrc) begin
            frames_done <= frames_done + CNT_W'(1);
        end
    end

`ifdef PARITY_CHECK_EN
    logic exp_parity;

    assign exp_parity = (^s_data) ^ beat_mode;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_err   <= 1'b0;
            err_count <= '0;
        end else if (in_fire && (s_parity != exp_parity)) begin
            par_err <= 1'b1;
            if (err_count != {CNT_W{1'b1}}) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end
`endif

endmodule
